// File: rtl/spi_reg_bank.sv
// spi_reg_bank: SPI command decoder and 8-bit control register bank.
// Parses {rw, addr} command bytes and data bytes from the SPI slave,
// updates registers, loads read data / status into the slave TX byte.
// Ports: i_Clk, i_Rst (async, active-high), i_SPI_CS_n (raw CS),
//   i_RX_DV/i_RX_Byte (received byte), o_TX_DV/o_TX_Byte (TX load),
//   i_Status (live status at top address), o_Regs (flattened bank),
//   o_Wr_Strobe/o_Wr_Addr (accepted write indication).
// Option: define SPI_REG_AUTOINC_EN for burst mode (address auto-increment).
module spi_reg_bank #(
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 3
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    input  logic                  i_SPI_CS_n,
    input  logic                  i_RX_DV,
    input  logic [7:0]            i_RX_Byte,
    output logic                  o_TX_DV,
    output logic [7:0]            o_TX_Byte,
    input  logic [7:0]            i_Status,
    output logic [8*NUM_REGS-1:0] o_Regs,
    output logic                  o_Wr_Strobe,
    output logic [ADDR_W-1:0]     o_Wr_Addr
);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        DONE
    } state_t;

    localparam logic [ADDR_W-1:0] TOP = ADDR_W'(NUM_REGS - 1);

    state_t              state;
    state_t              state_n;
    logic                cs_meta;
    logic                cs_sync;
    logic                cs_prev;
    logic                boot;
    logic                rw_q;
    logic                bad_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [7:0]          regs [NUM_REGS];

    logic                cmd_rw;
    logic                cmd_bad;
    logic [ADDR_W-1:0]   cmd_addr;
    logic [ADDR_W-1:0]   next_addr;
    logic [ADDR_W-1:0]   rd_addr;
    logic                rd_bad;
    logic [7:0]          rd_val;
    logic                tx_dv_n;
    logic [7:0]          tx_byte_n;
    logic                wr_en;

    assign cmd_rw    = i_RX_Byte[7];
    assign cmd_addr  = i_RX_Byte[ADDR_W-1:0];
    assign cmd_bad   = |i_RX_Byte[6:ADDR_W];
    assign next_addr = addr_q + 1'b1;

    // One read port serves both the command byte (new address) and
    // burst data bytes (incremented address).
    always_comb begin
        rd_addr = (state == IDLE) ? cmd_addr : next_addr;
        rd_bad  = (state == IDLE) ? cmd_bad : bad_q;
        if (rd_bad) begin
            rd_val = 8'h00;
        end else if (rd_addr == TOP) begin
            rd_val = i_Status;
        end else begin
            rd_val = regs[rd_addr];
        end
    end

    always_comb begin
        state_n   = state;
        tx_dv_n   = 1'b0;
        tx_byte_n = o_TX_Byte;
        wr_en     = 1'b0;
        if (i_RX_DV) begin
            unique case (state)
                IDLE: begin
                    state_n   = DATA;
                    tx_dv_n   = 1'b1;
                    tx_byte_n = cmd_rw ? rd_val : 8'h00;
                end
                DATA: begin
                    wr_en = !rw_q && !bad_q && (addr_q != TOP);
`ifdef SPI_REG_AUTOINC_EN
                    state_n = DATA;
                    if (rw_q) begin
                        tx_dv_n   = 1'b1;
                        tx_byte_n = rd_val;
                    end
`else
                    state_n = DONE;
`endif
                end
                DONE: begin
                    state_n = DONE;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
        // Frame-start status load overrides any byte-triggered load.
        if (boot || (cs_sync && !cs_prev)) begin
            tx_dv_n   = 1'b1;
            tx_byte_n = i_Status;
        end
        if (cs_sync) begin
            state_n = IDLE;
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            cs_meta     <= 1'b1;
            cs_sync     <= 1'b1;
            cs_prev     <= 1'b1;
            boot        <= 1'b1;
            state       <= IDLE;
            rw_q        <= 1'b0;
            bad_q       <= 1'b0;
            addr_q      <= '0;
            o_TX_DV     <= 1'b0;
            o_TX_Byte   <= 8'h00;
            o_Wr_Strobe <= 1'b0;
            o_Wr_Addr   <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= 8'h00;
            end
        end else begin
            cs_meta     <= i_SPI_CS_n;
            cs_sync     <= cs_meta;
            cs_prev     <= cs_sync;
            boot        <= 1'b0;
            state       <= state_n;
            o_TX_DV     <= tx_dv_n;
            o_TX_Byte   <= tx_byte_n;
            o_Wr_Strobe <= wr_en;
            if (wr_en) begin
                regs[addr_q] <= i_RX_Byte;
                o_Wr_Addr    <= addr_q;
            end
            if (i_RX_DV && state == IDLE) begin
                rw_q   <= cmd_rw;
                bad_q  <= cmd_bad;
                addr_q <= cmd_addr;
            end
`ifdef SPI_REG_AUTOINC_EN
            else if (i_RX_DV && state == DATA) begin
                addr_q <= next_addr;
            end
`endif
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            o_Regs[8*i +: 8] = regs[i];
        end
    end

endmodule

// File: tb/tb_spi_reg_bank.sv
// tb_spi_reg_bank: self-checking bench for spi_reg_bank.
// Byte-level reference model compared every cycle, plus directed literals.
module tb_spi_reg_bank;

    localparam int N = 8;
`ifdef SPI_REG_AUTOINC_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          cs_n;
    logic          rx_dv;
    logic [7:0]    rx_byte;
    logic          tx_dv;
    logic [7:0]    tx_byte;
    logic [7:0]    status;
    logic [8*N-1:0] regs;
    logic          wr_strobe;
    logic [2:0]    wr_addr;

    int checks = 0;
    int errors = 0;
    int stb_cnt = 0;

    always #5 clk = ~clk;

    spi_reg_bank #(.NUM_REGS(N), .ADDR_W(3)) dut (
        .i_Clk(clk),
        .i_Rst(rst),
        .i_SPI_CS_n(cs_n),
        .i_RX_DV(rx_dv),
        .i_RX_Byte(rx_byte),
        .o_TX_DV(tx_dv),
        .o_TX_Byte(tx_byte),
        .i_Status(status),
        .o_Regs(regs),
        .o_Wr_Strobe(wr_strobe),
        .o_Wr_Addr(wr_addr)
    );

    // Reference model: counts bytes within a frame; CS goes through a
    // two-cycle delay line before it is seen.
    logic [7:0] m_regs [N];
    logic       e_tx_dv, e_stb;
    logic [7:0] e_tx;
    logic [2:0] e_wa;
    logic       s0, s1, prev, boot;
    int         nb;
    logic       m_rw, m_bad;
    int         m_addr;

    function automatic logic [7:0] rd(input int a);
        if (m_bad) return 8'h00;
        if (a == N - 1) return status;
        return m_regs[a];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) m_regs[i] = 8'h00;
            e_tx_dv = 0; e_tx = 0; e_stb = 0; e_wa = 0;
            s0 = 1; s1 = 1; prev = 1; boot = 1; nb = 0;
            m_rw = 0; m_bad = 0; m_addr = 0;
        end else begin
            e_tx_dv = 0;
            e_stb = 0;
            if (rx_dv) begin
                if (nb == 0) begin
                    m_rw = rx_byte[7];
                    m_addr = int'(rx_byte) % N;
                    m_bad = int'(rx_byte & 8'h7F) >= N;
                    e_tx_dv = 1;
                    e_tx = m_rw ? rd(m_addr) : 8'h00;
                    nb = 1;
                end else if (nb == 1 || AUTO) begin
                    if (!m_rw && !m_bad && m_addr != N - 1) begin
                        m_regs[m_addr] = rx_byte;
                        e_stb = 1;
                        e_wa = 3'(m_addr);
                    end
                    if (AUTO) begin
                        m_addr = (m_addr + 1) % N;
                        if (m_rw) begin
                            e_tx_dv = 1;
                            e_tx = rd(m_addr);
                        end
                    end
                    nb++;
                end
            end
            if (boot || (s1 && !prev)) begin
                e_tx_dv = 1;
                e_tx = status;
            end
            if (s1) nb = 0;
            boot = 0;
            prev = s1;
            s1 = s0;
            s0 = cs_n;
        end
    end

    always @(negedge clk) begin
        logic [8*N-1:0] er;
        for (int i = 0; i < N; i++) er[8*i +: 8] = m_regs[i];
        checks += 5;
        if (tx_dv !== e_tx_dv) begin
            errors++;
            $display("FAIL tx_dv t=%0t got %b exp %b", $time, tx_dv, e_tx_dv);
        end
        if (tx_byte !== e_tx) begin
            errors++;
            $display("FAIL tx_byte t=%0t got %h exp %h", $time, tx_byte, e_tx);
        end
        if (regs !== er) begin
            errors++;
            $display("FAIL regs t=%0t got %h exp %h", $time, regs, er);
        end
        if (wr_strobe !== e_stb) begin
            errors++;
            $display("FAIL strobe t=%0t got %b exp %b", $time, wr_strobe, e_stb);
        end
        if (wr_addr !== e_wa) begin
            errors++;
            $display("FAIL wr_addr t=%0t got %0d exp %0d", $time, wr_addr, e_wa);
        end
        if (wr_strobe === 1'b1) stb_cnt++;
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, act, exp);
        end
    endtask

    bit rnd_status = 0;

    task automatic send(input logic [7:0] b, output logic dv,
                        output logic [7:0] tb);
        @(posedge clk);
        #1;
        rx_dv = 1;
        rx_byte = b;
        if (rnd_status) status = 8'($urandom);
        @(posedge clk);
        #1;
        rx_dv = 0;
        @(negedge clk);
        dv = tx_dv;
        tb = tx_byte;
    endtask

    task automatic cs_low();
        @(posedge clk);
        #1 cs_n = 0;
        repeat (3) @(posedge clk);
    endtask

    task automatic wait_status(input string name, input logic [7:0] exp);
        bit seen = 0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            if (tx_dv) begin
                seen = 1;
                chk(name, 64'(tx_byte), 64'(exp));
            end
        end
        if (!seen) chk({name, "_timeout"}, 64'(0), 64'(1));
    endtask

    task automatic cs_high(input string name);
        @(posedge clk);
        #1 cs_n = 1;
        wait_status(name, status);
    endtask

    initial begin
        logic dv;
        logic [7:0] b;
        int s0c;
        rst = 1; cs_n = 1; rx_dv = 0; rx_byte = 0; status = 8'h5A;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        wait_status("boot_status", 8'h5A);

        cs_low();
        send(8'h02, dv, b);
        chk("wcmd_tx", {dv, b}, {1'b1, 8'h00});
        send(8'h3C, dv, b);
        chk("reg2", 64'(regs[23:16]), 64'h3C);
        chk("stb", 64'(wr_strobe), 64'd1);
        chk("waddr", 64'(wr_addr), 64'd2);
        cs_high("frame_status");

        cs_low();
        send(8'h82, dv, b);
        chk("rd2", {dv, b}, {1'b1, 8'h3C});
        send(8'hFF, dv, b);
        chk("regs_after_rd", regs, 64'h0000_0000_003C_0000);
        cs_high("st2");

        s0c = stb_cnt;
        cs_low(); send(8'h07, dv, b); send(8'h11, dv, b); cs_high("st3");
        cs_low(); send(8'h12, dv, b); send(8'h22, dv, b); cs_high("st4");
        chk("no_strobe", 64'(stb_cnt - s0c), 64'd0);
        chk("regs_kept", regs, 64'h0000_0000_003C_0000);
        cs_low();
        send(8'h92, dv, b);
        chk("rd_bad", {dv, b}, {1'b1, 8'h00});
        cs_high("st5");

        cs_low();
        send(8'h06, dv, b); send(8'hA1, dv, b);
        send(8'hA2, dv, b); send(8'hA3, dv, b);
        chk("burst_r6", 64'(regs[55:48]), 64'hA1);
        chk("burst_r7", 64'(regs[63:56]), 64'h00);
        chk("burst_r0", 64'(regs[7:0]), AUTO ? 64'hA3 : 64'h00);
        cs_high("st6");

        cs_low();
        send(8'h03, dv, b);
        @(posedge clk);
        #3 rst = 1;
        #1;
        chk("rst_tx", {tx_dv, tx_byte}, 64'd0);
        chk("rst_regs", regs, 64'd0);
        chk("rst_wr", {wr_strobe, wr_addr}, 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 0;
        repeat (4) @(posedge clk);
        send(8'h04, dv, b);
        send(8'h77, dv, b);
        chk("post_rst_r4", 64'(regs[39:32]), 64'h77);
        chk("post_rst_r3", 64'(regs[31:24]), 64'h00);
        cs_high("st7");

        rnd_status = 1;
        repeat (250) begin
            logic [7:0] cmd;
            int nd;
            cs_low();
            cmd = 8'($urandom);
            if ($urandom_range(0, 3) != 0) cmd[6:3] = 4'h0;
            nd = $urandom_range(0, 4);
            send(cmd, dv, b);
            for (int k = 0; k < nd; k++) begin
                repeat ($urandom_range(0, 2)) @(posedge clk);
                send(8'($urandom), dv, b);
            end
            @(posedge clk);
            #1 cs_n = 1;
            repeat ($urandom_range(3, 6)) @(posedge clk);
        end
        repeat (4) @(posedge clk);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
